// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-Lite definitions: transfer types, response codes, the slave
// register map and the master FSM state encoding.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_t;

    localparam logic OKAY  = 1'b0;
    localparam logic ERROR = 1'b1;

    localparam int unsigned ERR_STATUS_ADDRESS = 1;
    localparam int unsigned PAYLOAD_ADDRESS    = 2;
    localparam int unsigned DATA_SIZE_ADDRESS  = 4;

    typedef enum logic [1:0] {
        M_IDLE,
        M_ACTIVE,
        M_ERROR
    } master_state_t;

endpackage

// File: rtl/ahb_lite_master_if.sv
// Command/response handshake plus AHB-Lite bus signals of the master.
interface ahb_lite_master_if
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [2:0]            cmd_size;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_abort;

    logic                  hsel_x;
    logic [ADDR_WIDTH-1:0] haddr;
    htrans_t               htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_abort,
        output hsel_x, haddr, htrans, hwrite, hsize, hwdata,
        input  hready, hrdata, hresp
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_abort,
        input  hsel_x, haddr, htrans, hwrite, hsize, hwdata,
        output hready, hrdata, hresp
    );

endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite master with a two-stage address/data pipeline: the address
// phase of the next command overlaps the data phase of the current one.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input logic              hclk,
    input logic              hreset_n,
    ahb_lite_master_if.master bus
);

    master_state_t         state;

    logic                  a_valid;
    logic                  a_write;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [2:0]            a_size;
    logic [DATA_WIDTH-1:0] a_wdata;

    logic                  d_valid;
    logic                  d_write;
    logic [DATA_WIDTH-1:0] d_wdata;

    logic                  hsel_q;
    htrans_t               htrans_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic                  rsp_abort_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic                  cmd_fire;

    // Commands are refused during the second error cycle and while in reset.
    assign bus.cmd_ready = bus.hready && (state != M_ERROR) && hreset_n;
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;

    // Bus outputs are taken straight from the stage registers.
    assign bus.hsel_x    = hsel_q;
    assign bus.htrans    = htrans_q;
    assign bus.haddr     = a_addr;
    assign bus.hwrite    = a_write;
    assign bus.hsize     = a_size;
    assign bus.hwdata    = d_wdata;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_abort = rsp_abort_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // Pipeline advance, error handling and one-cycle response generation.
    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state       <= M_IDLE;
            a_valid     <= 1'b0;
            a_write     <= 1'b0;
            a_addr      <= '0;
            a_size      <= '0;
            a_wdata     <= '0;
            d_valid     <= 1'b0;
            d_write     <= 1'b0;
            d_wdata     <= '0;
            hsel_q      <= 1'b0;
            htrans_q    <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_abort_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_abort_q <= 1'b0;
            rsp_rdata_q <= '0;
            case (state)
                M_IDLE, M_ACTIVE: begin
                    if (bus.hready) begin
                        if (d_valid) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= d_write ? '0 : bus.hrdata;
                        end
                        d_valid <= a_valid;
                        d_write <= a_write;
                        d_wdata <= a_wdata;
                        a_valid <= cmd_fire;
                        if (cmd_fire) begin
                            a_write <= bus.cmd_write;
                            a_addr  <= bus.cmd_addr;
                            a_size  <= bus.cmd_size;
                            a_wdata <= bus.cmd_wdata;
                        end
                        htrans_q <= cmd_fire ? NONSEQ : IDLE;
                        hsel_q   <= cmd_fire || a_valid;
                        state    <= (cmd_fire || a_valid) ? M_ACTIVE : M_IDLE;
                    end else if (bus.hresp == ERROR && d_valid) begin
                        a_valid  <= 1'b0;
                        htrans_q <= IDLE;
                        hsel_q   <= 1'b1;
                        if (a_valid) begin
                            rsp_valid_q <= 1'b1;
                            rsp_abort_q <= 1'b1;
                        end
                        state <= M_ERROR;
                    end
                end
                M_ERROR: begin
                    if (bus.hready) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        d_valid     <= 1'b0;
                        hsel_q      <= 1'b0;
                        state       <= M_IDLE;
                    end
                end
                default: state <= M_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

Single-outstanding-pipeline AHB-Lite master that converts a simple command/response handshake into AHB address/data-phase transfers. It sits directly upstream of `AHB_interface` and drives that slave's `hsel_x/haddr/htrans/hwrite/hsize/hwdata`. It consumes `hready_out`, `hrdata` and `hresp`. It overlaps the address phase of command N+1 with the data phase of command N.

## Interface
- `ADDR_WIDTH`, 3: width of `haddr`/`cmd_addr`
- `DATA_WIDTH`, 8: width of `hwdata`/`hrdata`/`cmd_wdata`/`rsp_rdata`
- `hclk`  in  1  clock; one clock domain; all logic on posedge
- `hreset_n`  in  1  reset; synchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted on edge where `cmd_valid && cmd_ready`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_WIDTH  target address
- `cmd_size`  in  3  passed to `hsize` unchanged
- `cmd_wdata`  in  DATA_WIDTH  write data
- `rsp_valid`  out  1  one-cycle response pulse
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes, aborts and errors
- `rsp_err`  out  1  slave returned ERROR for this transfer
- `rsp_abort`  out  1  command dropped before its data phase, because the previous transfer errored
- `hsel_x`  out  1  slave select; high while the address stage or the data stage is valid
- `haddr`  out  ADDR_WIDTH  address-phase address
- `htrans`  out  2  `2'd2` NONSEQ when the address stage is valid, else `2'd0` IDLE; BUSY/SEQ never driven
- `hwrite`  out  1  address-phase direction
- `hsize`  out  3  address-phase size
- `hwdata`  out  DATA_WIDTH  data-phase write data, held from the data stage
- `hready`  in  1  transfer-done from slave (`hready_out` of the slave)
- `hrdata`  in  DATA_WIDTH  slave read data
- `hresp`  in  1  0 = OKAY, 1 = ERROR

## Operation
- Two registered stages:
  - A (address phase): valid, write, addr, size, wdata.
  - D (data phase): valid, write, wdata.
- Bus address outputs come only from stage A. `hwdata` comes only from stage D.
- FSM states:
  - IDLE: A and D empty.
  - ACTIVE: A or D valid.
  - ERROR: second cycle of a two-cycle error response.
- `cmd_ready = hready && state != ERROR && hreset_n`.
- Edge with `hready=1`, `hresp=0`:
  - If D was valid, a response is issued: `rsp_valid=1`, `rsp_err=0`, and `rsp_rdata` = `hrdata` for reads or 0 for writes.
  - D <= A.
  - A <= accepted command, or invalid if no command was accepted.
- Edge with `hready=0`, `hresp=0`: wait state; A, D and all bus outputs hold.
- Edge with `hready=0`, `hresp=1` and D valid (first error cycle):
  - A is cleared, so `htrans` goes to IDLE from the next cycle.
  - If A was valid, an abort response is issued for it: `rsp_valid=1`, `rsp_abort=1`, `rsp_err=0`.
  - Go to ERROR.
- In ERROR, on the edge with `hready=1`, `hresp=1`:
  - Issue `rsp_valid=1`, `rsp_err=1` for D.
  - D cleared; go to IDLE.
  - No command is accepted on this edge.
- In ERROR, an edge with `hready=0` holds the state.
- `hresp=1` while D is invalid is ignored (protocol violation, no response).
- Next-state after a response: IDLE if A and D are both empty, else ACTIVE.

## Timing
- All outputs registered except `cmd_ready`, which is combinational from `hready`/state.
- Reset: the edge with `hreset_n=0` sets:
  - A and D invalid, state IDLE.
  - `hsel_x`, `htrans`, `haddr`, `hwrite`, `hsize`, `hwdata` = 0.
  - `rsp_valid`, `rsp_err`, `rsp_abort`, `rsp_rdata` = 0.
- Reset mid-transfer drops both stages silently; no response is issued.
- Zero-wait latency:
  - Command accepted at edge T0 → address phase T0–T1 → data phase T1–T2 → `rsp_valid` high for cycle T2–T3.
  - Back-to-back throughput is 1 command/cycle.
- Each wait cycle (`hready=0`) adds one cycle. The response pulse is always exactly one cycle.
- Responses are returned in command order. At most one response is issued per edge.

## Structure
- Shared package `ahb_pkg`:
  - `htrans_t` enum: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - `hresp` constants OKAY=0 and ERROR=1.
  - Slave register map constants, shared with `AHB_interface` and its bench: ERR_STATUS_ADDRESS=1, PAYLOAD_ADDRESS=2, DATA_SIZE_ADDRESS=4.
  - Master FSM state enum.
- No sub-module; a single flat module of roughly 150–250 lines.

## Test plan
- Write `data_size`: cmd write addr 4, size 0, wdata 12, slave zero-wait → NONSEQ on bus for 1 cycle, `hwdata=12` next cycle, `rsp_valid` with `rsp_err=0`; slave `data_size` = 12.
- Back-to-back pipelining: write addr 2 wdata `8'b00101001`, then read addr 4 in consecutive cycles → address of the read overlaps the data phase of the write; read response `rsp_rdata=12` two cycles after its acceptance.
- Wait states: slave holds `hready_out=0` for 2 cycles during a data phase → `haddr`/`htrans`/`hwdata` stable, `cmd_ready=0`, response delayed by 2 cycles.
- Error: slave drives `hresp=1, hready=0` then `hresp=1, hready=1`, with a queued command in stage A → abort response (`rsp_abort=1`) first, then an error response (`rsp_err=1`) next cycle; `htrans=IDLE` during the second error cycle.
- Reset mid-operation: assert `hreset_n=0` while in the address phase of a write to addr 4 → at the next edge all outputs are 0 and no `rsp_valid` is ever issued; the first command after release completes normally.
